// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// ARB_TIMEOUT_EN (see rr_arbiter_8) uses HOLD_MAX / CNT_W from here.
package arb_pkg;

  localparam int N_REQ    = 8;
  localparam int IDX_W    = 3;
  localparam int HOLD_MAX = 16;
  localparam int CNT_W    = $clog2(HOLD_MAX);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef struct packed {
    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
  } arb_dbg_t;

endpackage

// File: rtl/rr_prio_sel.sv
// Rotating-priority selector: the first set request at or after ptr+1 (mod N_REQ) wins.
// Purely combinational; the caller registers the result.
module rr_prio_sel
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0]   base;
  logic [2*N_REQ-2:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   pick;

  always_comb begin
    base = ptr + IDX_W'(1);
    // Doubling the vector turns the rotate into a plain part-select.
    dbl  = {req[N_REQ-2:0], req};
    rot  = dbl[base +: N_REQ];
    pick = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) pick = IDX_W'(i);
    end
    idx = pick + base;
    any = |req;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with registered one-hot grant and owner index.
// Optional forced release after HOLD_MAX cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter_8
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             timeout,
  output arb_dbg_t         dbg
);

  // Handshake: agent k raises req[k] and keeps it high until it sees gnt[k];
  // the owner keeps the grant until it pulses done or drops req[k], and the
  // arbiter then spends one idle cycle before granting again.

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] win_idx;
  logic             win_any;
  logic             rel;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  rr_prio_sel u_sel (
    .req (req),
    .ptr (ptr_q),
    .idx (win_idx),
    .any (win_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    rel     = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_any) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          idx_d          = win_idx;
          state_d        = GRANT;
`ifdef ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      GRANT: begin
        rel = done | ~req[idx_q];
`ifdef ARB_TIMEOUT_EN
        // A normal release wins over the forced one, so no pulse in that case.
        if (!rel && (cnt_q == CNT_W'(HOLD_MAX - 1))) begin
          rel       = 1'b1;
          timeout_d = 1'b1;
        end
        cnt_d = cnt_q + CNT_W'(1);
`endif
        if (rel) begin
          gnt_d   = '0;
          idx_d   = '0;
          ptr_d   = idx_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(N_REQ - 1);
      gnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_vld   = |gnt_q;
  assign dbg.state = state_q;
  assign dbg.ptr   = ptr_q;

endmodule
